seg_digit_driver: RTL and testbench

Display back-end for the 4-digit seven-segment panel. It consumes the digit select and anode enables from the scan-clock divider, holds a 16-bit value to show (e.g. PC or ALU result from the single-cycle CPU), and drives registered active-low segment, decimal-point and anode lines. A double-buffered display register commits new data only at frame boundaries, so digits never tear. A one-cycle anode blank on every digit change suppresses ghosting.

---
 rtl/seg_digit_driver.sv | 141 ++++++++++++++
 tb/tb_seg_digit_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_driver.sv
// Seven-segment back-end for a 4-digit panel: double-buffered display value,
// frame-boundary commit, one-cycle anode blank on digit change, optional
// leading-zero suppression. All panel outputs are registered and active-low.
module seg_digit_driver #(
  parameter bit BLANK_LZ_DEFAULT = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_data,
  input  logic [3:0]  I_dp,
  input  logic        I_load,
  input  logic        I_blank_lz,
  input  logic [1:0]  I_sw,
  input  logic [3:0]  I_ands,
  output logic [6:0]  O_seg,
  output logic        O_dp,
  output logic [3:0]  O_an,
  output logic        O_pending,
  output logic        O_frame
);

  logic [15:0] shadow_data_q;
  logic [3:0]  shadow_dp_q;
  logic [15:0] active_data_q;
  logic [3:0]  active_dp_q;
  logic        pending_q;
  logic [1:0]  sw_q;
  logic        blank_lz_q;

  logic        wrap;
  logic        chg;
  logic [3:0]  nibble;
  logic        lead_zero;
  logic        dp_sel;
  logic [6:0]  seg_d;

  // Frame boundary is only the 3->0 step; any other select change is a plain digit change.
  assign wrap      = (sw_q == 2'd3) && (I_sw == 2'd0);
  assign chg       = (I_sw != sw_q);
  assign O_pending = pending_q;

  // Pick the digit's nibble and decide whether it sits inside a run of leading zeros.
  always_comb begin
    nibble    = active_data_q[15:12];
    lead_zero = 1'b0;
    dp_sel    = active_dp_q[3];
    case (I_sw)
      2'd0: begin
        nibble    = active_data_q[15:12];
        lead_zero = (active_data_q[15:12] == 4'h0);
        dp_sel    = active_dp_q[3];
      end
      2'd1: begin
        nibble    = active_data_q[11:8];
        lead_zero = (active_data_q[15:8] == 8'h00);
        dp_sel    = active_dp_q[2];
      end
      2'd2: begin
        nibble    = active_data_q[7:4];
        lead_zero = (active_data_q[15:4] == 12'h000);
        dp_sel    = active_dp_q[1];
      end
      default: begin
        // Rightmost digit always shows, so zero displays as a single "0".
        nibble    = active_data_q[3:0];
        lead_zero = 1'b0;
        dp_sel    = active_dp_q[0];
      end
    endcase
  end

  // Hex decode to active-low {a..g}, or all-off when suppressed as a leading zero.
  always_comb begin
    seg_d = 7'h7F;
    if (!(blank_lz_q && lead_zero)) begin
      case (nibble)
        4'h0: seg_d = 7'h01;
        4'h1: seg_d = 7'h4F;
        4'h2: seg_d = 7'h12;
        4'h3: seg_d = 7'h06;
        4'h4: seg_d = 7'h4C;
        4'h5: seg_d = 7'h24;
        4'h6: seg_d = 7'h20;
        4'h7: seg_d = 7'h0F;
        4'h8: seg_d = 7'h00;
        4'h9: seg_d = 7'h04;
        4'hA: seg_d = 7'h08;
        4'hB: seg_d = 7'h60;
        4'hC: seg_d = 7'h31;
        4'hD: seg_d = 7'h42;
        4'hE: seg_d = 7'h30;
        default: seg_d = 7'h38;
      endcase
    end
  end

  // Buffer management and registered panel outputs.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      shadow_data_q <= 16'h0000;
      shadow_dp_q   <= 4'h0;
      active_data_q <= 16'h0000;
      active_dp_q   <= 4'h0;
      pending_q     <= 1'b0;
      sw_q          <= 2'd0;
      blank_lz_q    <= BLANK_LZ_DEFAULT;
      O_seg         <= 7'h7F;
      O_dp          <= 1'b1;
      O_an          <= 4'hF;
      O_frame       <= 1'b0;
    end else begin
      sw_q       <= I_sw;
      blank_lz_q <= I_blank_lz;

      if (I_load) begin
        shadow_data_q <= I_data;
        shadow_dp_q   <= I_dp;
      end

      if (wrap) begin
        // A load landing on the boundary bypasses the shadow so it is not a frame late.
        if (I_load) begin
          active_data_q <= I_data;
          active_dp_q   <= I_dp;
        end else if (pending_q) begin
          active_data_q <= shadow_data_q;
          active_dp_q   <= shadow_dp_q;
        end
        pending_q <= 1'b0;
      end else if (I_load) begin
        pending_q <= 1'b1;
      end

      O_seg   <= seg_d;
      O_dp    <= ~dp_sel;
      O_an    <= chg ? 4'hF : I_ands;
      O_frame <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_digit_driver.sv
// Bench for seg_digit_driver: directed scenarios plus a randomized scan phase,
// all outputs compared every cycle against a value-level reference model.
module tb_seg_digit_driver;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        blz;
  logic [1:0]  sw;
  logic [3:0]  ands;
  logic [6:0]  seg;
  logic        odp;
  logic [3:0]  an;
  logic        pend;
  logic        frame;

  seg_digit_driver #(
    .BLANK_LZ_DEFAULT(1'b1)
  ) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_data     (data),
    .I_dp       (dp),
    .I_load     (load),
    .I_blank_lz (blz),
    .I_sw       (sw),
    .I_ands     (ands),
    .O_seg      (seg),
    .O_dp       (odp),
    .O_an       (an),
    .O_pending  (pend),
    .O_frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the panel should be holding, in plain value terms.
  logic [15:0] m_sh_data, m_act_data;
  logic [3:0]  m_sh_dp, m_act_dp;
  logic        m_pend;
  logic [1:0]  m_sw;
  logic        m_blz;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_frame;

  int          hold;
  logic [1:0]  nsw;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Digit k shows nibble k of v; blank when nibbles 0..k are all zero (except the last digit).
  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int k, input logic bl);
    logic [15:0] lead;
    lead = v >> (12 - 4 * k);
    if (bl && k < 3 && lead == 16'd0) return 7'h7F;
    return HEX[lead[3:0]];
  endfunction

  task automatic model_reset();
    m_sh_data  = '0;
    m_sh_dp    = '0;
    m_act_data = '0;
    m_act_dp   = '0;
    m_pend     = 1'b0;
    m_sw       = 2'd0;
    m_blz      = 1'b1;
    e_seg      = 7'h7F;
    e_dp       = 1'b1;
    e_an       = 4'hF;
    e_frame    = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare all outputs.
  task automatic cyc();
    int k;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      k       = int'(sw);
      e_seg   = ref_seg(m_act_data, k, m_blz);
      e_dp    = ~m_act_dp[3-k];
      e_an    = (sw != m_sw) ? 4'hF : ands;
      e_frame = (m_sw == 2'd3) && (sw == 2'd0);
      if (load) begin
        m_sh_data = data;
        m_sh_dp   = dp;
      end
      if (e_frame) begin
        if (load) begin
          m_act_data = data;
          m_act_dp   = dp;
        end else if (m_pend) begin
          m_act_data = m_sh_data;
          m_act_dp   = m_sh_dp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      m_sw  = sw;
      m_blz = blz;
    end
    #1;
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(odp), 16'(e_dp));
    check("an", 16'(an), 16'(e_an));
    check("frame", 16'(frame), 16'(e_frame));
    check("pending", 16'(pend), 16'(m_pend));
  endtask

  // Scan one frame 0..3 (entered from digit 3) and check the visible digits against constants.
  task automatic frame_expect(input int hd, input logic [27:0] segs, input logic [3:0] dpv,
                              input logic wrap_load, input logic [15:0] wdata);
    logic e1;
    for (int d = 0; d < 4; d++) begin
      sw   = 2'(d);
      ands = ~(4'b1000 >> d);
      if (d == 0 && wrap_load) begin
        load = 1'b1;
        data = wdata;
        dp   = 4'h0;
      end
      cyc();
      load = 1'b0;
      check("blank_an", 16'(an), 16'hF);
      if (d == 0) check("frame_pulse", 16'(frame), 16'd1);
      cyc();
      e1 = ~dpv[3-d];
      check("digit_seg", 16'(seg), 16'(segs[27-7*d -: 7]));
      check("digit_dp", 16'(odp), 16'(e1));
      check("digit_an", 16'(an), 16'(ands));
      for (int i = 2; i < hd; i++) cyc();
    end
  endtask

  task automatic hold_digit(input logic [1:0] s, input int n);
    sw   = s;
    ands = ~(4'b1000 >> s);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    model_reset();
    rst  = 1'b1;
    data = '0;
    dp   = '0;
    load = 1'b0;
    blz  = 1'b1;
    sw   = '0;
    ands = 4'hF;

    // Reset held with random scan inputs.
    for (int i = 0; i < 5; i++) begin
      sw   = 2'($urandom_range(0, 3));
      ands = 4'($urandom);
      cyc();
    end
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(odp), 16'd1);
    check("rst_an", 16'(an), 16'hF);
    check("rst_pending", 16'(pend), 16'd0);
    check("rst_frame", 16'(frame), 16'd0);

    // Release mid-frame; a load must wait for the first 3->0 wrap.
    sw   = 2'd2;
    ands = 4'b1101;
    rst  = 1'b0;
    cyc();
    cyc();
    load = 1'b1;
    data = 16'h12AF;
    dp   = 4'b0010;
    cyc();
    load = 1'b0;
    check("load_pending", 16'(pend), 16'd1);
    cyc();
    hold_digit(2'd3, 2);
    check("pre_commit_seg", 16'(seg), 16'h01);
    cyc();
    frame_expect(3, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b0010, 1'b0, 16'h0);

    // Tear-free update: load during digit 1, old frame completes, new one shows F's.
    hold_digit(2'd0, 3);
    hold_digit(2'd1, 1);
    load = 1'b1;
    data = 16'hFFFF;
    dp   = 4'h0;
    cyc();
    load = 1'b0;
    check("tear_pending", 16'(pend), 16'd1);
    cyc();
    hold_digit(2'd2, 2);
    check("tear_old_seg", 16'(seg), 16'h08);
    cyc();
    hold_digit(2'd3, 3);
    check("tear_pending_wrap", 16'(pend), 16'd1);
    frame_expect(3, {4{7'h38}}, 4'h0, 1'b0, 16'h0);
    check("tear_pending_done", 16'(pend), 16'd0);

    // Leading-zero suppression on and off, and the all-zero value.
    load = 1'b1;
    data = 16'h0040;
    dp   = 4'h0;
    cyc();
    load = 1'b0;
    frame_expect(3, {7'h7F, 7'h7F, 7'h4C, 7'h01}, 4'h0, 1'b0, 16'h0);
    blz = 1'b0;
    cyc();
    frame_expect(3, {7'h01, 7'h01, 7'h4C, 7'h01}, 4'h0, 1'b0, 16'h0);
    blz  = 1'b1;
    load = 1'b1;
    data = 16'h0000;
    cyc();
    load = 1'b0;
    frame_expect(3, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'h0, 1'b0, 16'h0);

    // Load landing exactly on the wrap edge.
    frame_expect(3, {7'h60, 7'h30, 7'h30, 7'h38}, 4'h0, 1'b1, 16'hBEEF);
    check("coincident_pending", 16'(pend), 16'd0);

    // Back-to-back loads before a wrap: only the last is shown.
    load = 1'b1;
    data = 16'h1111;
    cyc();
    load = 1'b0;
    cyc();
    load = 1'b1;
    data = 16'h2222;
    cyc();
    load = 1'b0;
    frame_expect(3, {4{7'h12}}, 4'h0, 1'b0, 16'h0);

    // Randomized scan with jumps, loads, blanking toggles and occasional async resets.
    for (int it = 0; it < 250; it++) begin
      hold = $urandom_range(2, 6);
      if ($urandom_range(0, 4) == 0) nsw = 2'($urandom_range(0, 3));
      else nsw = sw + 2'd1;
      sw   = nsw;
      ands = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blz = ~blz;
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          load = 1'b1;
          data = 16'($urandom) >> $urandom_range(0, 16);
          dp   = 4'($urandom);
        end
        cyc();
        load = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        #1;
        check("async_rst_seg", 16'(seg), 16'h7F);
        check("async_rst_an", 16'(an), 16'hF);
        check("async_rst_pending", 16'(pend), 16'd0);
        cyc();
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
